dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the core's data-memory port: answers the pipelined RISC-V core's load/store requests with a fixed one-cycle read latency. Sits beside the core in the SoC top level. It decodes each request into either a word-addressed data RAM or a small MMIO register window containing a GPIO register, a 64-bit cycle counter, and a byte transmit FIFO that drains to a debug console sink.

## Interface
- ADDR_WIDTH, 10, RAM word-address bits (2^ADDR_WIDTH words, 4 KiB default)
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- dmem_read_i  in  1  load request this cycle
- dmem_write_i  in  1  store request this cycle
- dmem_addr_i  in  32  byte address (bits [1:0] ignored)
- dmem_data_i  in  32  store data from core
- dmem_data_o  out  32  load data, valid the cycle after dmem_read_i
- gpio_o  out  32  GPIO register contents
- tx_data_o  out  8  FIFO head byte; 0 when empty
- tx_valid_o  out  1  FIFO non-empty
- tx_ready_i  in  1  sink accepts byte when high with tx_valid_o

## Operation
- One clock; reset is synchronous and active-high.
- Decode: dmem_addr_i[31]=0 → RAM, index dmem_addr_i[ADDR_WIDTH+1:2]; higher bits ignored, so addresses alias modulo RAM size. dmem_addr_i[31]=1 → MMIO, offset dmem_addr_i[4:2].
- Word accesses only; no byte enables.
- MMIO map (byte offsets):
  - 0x00 GPIO: R/W
  - 0x04 CYCLE_LO: RO; read also latches counter[63:32] into a HI snapshot
  - 0x08 CYCLE_HI: RO; returns the snapshot
  - 0x0C TX_DATA: WO; pushes dmem_data_i[7:0]; reads 0
  - 0x10 TX_STATUS: R = {count, 3'b0, overflow, empty, full}, with count in bits [..:6]; a write with bit2=1 clears overflow
  - 0x14–0x1C: read 0, writes ignored
- Cycle counter: 64-bit, reads 0 in the first cycle reset is low, then increments by 1 every cycle and wraps to 0 from 2^64−1.
- TX FIFO:
  - Push to a full FIFO is dropped and sets sticky overflow.
  - Pop occurs when tx_valid_o and tx_ready_i are both high.
  - full/empty are evaluated on pre-cycle state: a push while full is dropped even if a pop occurs in the same cycle.
  - Push and pop on a non-full, non-empty FIFO both complete; count is unchanged.
  - Push to an empty FIFO makes tx_valid_o high the next cycle.
- Simultaneous read and write to the same location: the write takes effect and the read returns the pre-write value.
- With no read request, dmem_data_o holds its last value.
- Reset values:
  - dmem_data_o=0, gpio_o=0, tx_valid_o=0, tx_data_o=0
  - counter=0, HI snapshot=0, overflow=0, FIFO emptied
  - RAM contents are not reset and are preserved.

## Timing
- Read: request in cycle N; dmem_data_o is valid in cycle N+1 (registered).
- Write: RAM or register updates at the end of cycle N, visible to a read issued in N+1.
- CYCLE_LO read issued in cycle k after reset release returns k at cycle k+1. A subsequent CYCLE_HI read returns bits [63:32] of the counter as it was in cycle k.
- tx_data_o/tx_valid_o are combinational from FIFO state (no output register); pop takes effect at the clock edge.
- Reset asserted mid-operation: all state listed above is at its reset value in the following cycle. Any request in the reset cycle is ignored, except that RAM writes are also suppressed.

## Structure
- Shared package dmem_pkg: MMIO_BASE bit (31), offset constants for GPIO/CYCLE_LO/CYCLE_HI/TX_DATA/TX_STATUS, and TX_STATUS bit positions (FULL=0, EMPTY=1, OVF=2, COUNT_LSB=6).
- One sub-module, sync_fifo:
  - parameterised width/depth
  - push, pop, full, empty, count, head
  - pointers carry one extra wrap bit
- RAM is an inferred array inside dmem_responder.

## Test plan
- Write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 the next cycle → dmem_data_o=0xDEADBEEF one cycle after the read.
- Simultaneous read+write of 0x20 (old 0x11111111, new 0x22222222) → 0x11111111 returned; the following read returns 0x22222222.
- ADDR_WIDTH=10: write 0x5A5A5A5A to 0x0000_1004, read 0x0000_0004 → 0x5A5A5A5A (alias).
- TX FIFO overflow and drain:
  - tx_ready_i=0; write bytes 0x01..0x09 to TX_DATA → TX_STATUS full=1, overflow=1, count=8.
  - Raise tx_ready_i → 0x01..0x08 out one per cycle, then tx_valid_o=0 and empty=1.
  - Write 0x4 to TX_STATUS → overflow=0.
- Counter: read CYCLE_LO in cycle 5 after reset release → 5. Force counter to 0x0000_0000_FFFF_FFFF, read LO then HI → 0xFFFF_FFFF and 0x0000_0000.
- Reset mid-operation: gpio_o=0xA5, FIFO holding 3 bytes, pulse reset one cycle → gpio_o=0, tx_valid_o=0, dmem_data_o=0; previously written RAM word still reads back unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO decode bit, register
// byte offsets inside the MMIO window, and the TX_STATUS bit layout.
package dmem_pkg;

    // Address bit that selects the MMIO window over the data RAM
    localparam int unsigned MMIO_BASE_BIT = 31;

    // Width of the decoded MMIO byte offset (8 word registers)
    localparam int unsigned MMIO_OFF_W = 5;

    // MMIO register byte offsets
    localparam logic [MMIO_OFF_W-1:0] OFF_GPIO      = 5'h00;
    localparam logic [MMIO_OFF_W-1:0] OFF_CYCLE_LO  = 5'h04;
    localparam logic [MMIO_OFF_W-1:0] OFF_CYCLE_HI  = 5'h08;
    localparam logic [MMIO_OFF_W-1:0] OFF_TX_DATA   = 5'h0C;
    localparam logic [MMIO_OFF_W-1:0] OFF_TX_STATUS = 5'h10;

    // TX_STATUS bit positions
    localparam int unsigned ST_FULL      = 0;
    localparam int unsigned ST_EMPTY     = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_COUNT_LSB = 6;

    localparam int unsigned ST_COUNT_W = 32 - ST_COUNT_LSB;

    // Assemble the TX_STATUS read word; count occupies bits [31:6]
    function automatic logic [31:0] pack_tx_status(
        input logic [ST_COUNT_W-1:0] count,
        input logic                  ovf,
        input logic                  empty,
        input logic                  full
    );
        return {count, 3'b000, ovf, empty, full};
    endfunction

endpackage : dmem_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers.
// Ports: clk, reset (sync, active-high), push/din, pop, full, empty,
//        count (occupancy, 0..DEPTH), head (oldest entry, 0 when empty).
// Push while full and pop while empty are ignored; full/empty come from
// the pre-edge pointers, so a push on a full FIFO is dropped even with a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Status from pointer comparison: same index, different wrap bit => full
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        count   = wr_ptr - rd_ptr;
        head    = empty ? '0 : mem[rd_ptr[AW-1:0]];
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    // Pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage; contents are meaningless once pointers reset, so no reset here
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule : sync_fifo

// File: rtl/dmem_responder.sv
// Data-memory port responder for the core: word RAM plus an MMIO window with
// GPIO, a 64-bit cycle counter (LO read snapshots HI) and a TX byte FIFO.
// Ports: clk, reset (sync, active-high); dmem_read_i/dmem_write_i request
// strobes, dmem_addr_i byte address, dmem_data_i store data, dmem_data_o
// registered load data (one-cycle latency, holds between reads); gpio_o;
// tx_data_o/tx_valid_o FIFO head (combinational), tx_ready_i sink handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_read_i,
    input  logic        dmem_write_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_data_i,
    output logic [31:0] dmem_data_o,
    output logic [31:0] gpio_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);

    localparam int unsigned RAM_WORDS = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]           ram [RAM_WORDS];

    logic [31:0]           gpio_q;
    logic [63:0]           cycle_q;
    logic [31:0]           hi_snap_q;
    logic                  ovf_q;

    logic                  is_mmio;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [MMIO_OFF_W-1:0] mmio_off;

    logic [31:0]           rdata_c;
    logic                  ram_we_c;
    logic                  gpio_we_c;
    logic                  lo_rd_c;
    logic                  tx_push_c;
    logic                  ovf_clr_c;

    logic                  tx_full;
    logic                  tx_empty;
    logic [CNT_W-1:0]      tx_count;
    logic [7:0]            tx_head;
    logic                  tx_pop;

    // Address bits that do not participate in decode (RAM aliasing, byte lanes)
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{dmem_addr_i[30:ADDR_WIDTH+2], dmem_addr_i[1:0]};

    assign is_mmio  = dmem_addr_i[MMIO_BASE_BIT];
    assign ram_idx  = dmem_addr_i[ADDR_WIDTH+1:2];
    assign mmio_off = {dmem_addr_i[4:2], 2'b00};

    // Request decode: read mux and per-target write strobes
    always_comb begin
        rdata_c   = '0;
        ram_we_c  = 1'b0;
        gpio_we_c = 1'b0;
        lo_rd_c   = 1'b0;
        tx_push_c = 1'b0;
        ovf_clr_c = 1'b0;
        if (!is_mmio) begin
            rdata_c  = ram[ram_idx];
            ram_we_c = dmem_write_i && !reset;
        end else begin
            unique case (mmio_off)
                OFF_GPIO: begin
                    rdata_c   = gpio_q;
                    gpio_we_c = dmem_write_i;
                end
                OFF_CYCLE_LO: begin
                    rdata_c = cycle_q[31:0];
                    lo_rd_c = dmem_read_i;
                end
                OFF_CYCLE_HI: begin
                    rdata_c = hi_snap_q;
                end
                OFF_TX_DATA: begin
                    tx_push_c = dmem_write_i && !reset;
                end
                OFF_TX_STATUS: begin
                    rdata_c   = pack_tx_status(ST_COUNT_W'(tx_count), ovf_q,
                                               tx_empty, tx_full);
                    ovf_clr_c = dmem_write_i && dmem_data_i[ST_OVF];
                end
                default: begin
                end
            endcase
        end
    end

    // Register state; reads see pre-write values because updates are at the edge
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_data_o <= '0;
            gpio_q      <= '0;
            cycle_q     <= '0;
            hi_snap_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (dmem_read_i) dmem_data_o <= rdata_c;
            if (gpio_we_c)   gpio_q      <= dmem_data_i;
            if (lo_rd_c)     hi_snap_q   <= cycle_q[63:32];
            if (ovf_clr_c)
                ovf_q <= 1'b0;
            else if (tx_push_c && tx_full)
                ovf_q <= 1'b1;
        end
    end

    // Data RAM: not reset, write suppressed during reset via ram_we_c
    always_ff @(posedge clk) begin
        if (ram_we_c) ram[ram_idx] <= dmem_data_i;
    end

    assign tx_pop = tx_valid_o && tx_ready_i;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push_c),
        .din   (dmem_data_i[7:0]),
        .pop   (tx_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count),
        .head  (tx_head)
    );

    assign gpio_o     = gpio_q;
    assign tx_valid_o = !tx_empty;
    assign tx_data_o  = tx_head;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected load data is queued when a read
// is issued and compared when the registered response appears.
module tb_dmem_responder;

    localparam logic [31:0] A_GPIO   = 32'h8000_0000;
    localparam logic [31:0] A_LO     = 32'h8000_0004;
    localparam logic [31:0] A_HI     = 32'h8000_0008;
    localparam logic [31:0] A_TXD    = 32'h8000_000C;
    localparam logic [31:0] A_TXS    = 32'h8000_0010;
    localparam logic [31:0] A_UNMAP  = 32'h8000_0014;

    logic        clk;
    logic        reset;
    logic        dmem_read_i;
    logic        dmem_write_i;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_data_i;
    logic [31:0] dmem_data_o;
    logic [31:0] gpio_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;

    int unsigned n_cmp;
    int unsigned n_bad;
    logic [31:0] exp_q [$];
    logic        rd_pend;

    dmem_responder #(
        .ADDR_WIDTH (10),
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dmem_read_i  (dmem_read_i),
        .dmem_write_i (dmem_write_i),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_data_i  (dmem_data_i),
        .dmem_data_o  (dmem_data_o),
        .gpio_o       (gpio_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // A read accepted at an edge (outside reset) produces data after that edge
    always @(posedge clk) rd_pend <= dmem_read_i && !reset;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                check("rdata", {32'd0, dmem_data_o}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle; a read queues its expected response
    task automatic bus(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
        dmem_read_i  = rd;
        dmem_write_i = wr;
        dmem_addr_i  = addr;
        dmem_data_i  = wdata;
        if (rd) exp_q.push_back(exp);
        tick();
        dmem_read_i  = 1'b0;
        dmem_write_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
        bus(1'b0, 1'b1, addr, wdata, 32'd0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        bus(1'b1, 1'b0, addr, 32'd0, exp);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rd_pend      = 1'b0;
        reset        = 1'b1;
        dmem_read_i  = 1'b0;
        dmem_write_i = 1'b0;
        dmem_addr_i  = '0;
        dmem_data_i  = '0;
        tx_ready_i   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Cycle 0 after release: reset values
        @(negedge clk);
        check("rst_dout",  {32'd0, dmem_data_o}, 64'd0);
        check("rst_gpio",  {32'd0, gpio_o},      64'd0);
        check("rst_valid", {63'd0, tx_valid_o},  64'd0);
        check("rst_txd",   {56'd0, tx_data_o},   64'd0);

        // Advance to cycle 5 and read the counter
        repeat (5) tick();
        rd(A_LO, 32'd5);
        rd(A_HI, 32'd0);

        // RAM write then read
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, 32'hDEAD_BEEF);

        // Simultaneous read and write returns old data
        wr(32'h0000_0020, 32'h1111_1111);
        bus(1'b1, 1'b1, 32'h0000_0020, 32'h2222_2222, 32'h1111_1111);
        rd(32'h0000_0020, 32'h2222_2222);

        // Aliasing modulo RAM size
        wr(32'h0000_1004, 32'h5A5A_5A5A);
        rd(32'h0000_0004, 32'h5A5A_5A5A);

        // GPIO, unmapped and write-only registers
        wr(A_GPIO, 32'h1234_5678);
        check("gpio_out", {32'd0, gpio_o}, 64'h1234_5678);
        rd(A_GPIO, 32'h1234_5678);
        wr(A_UNMAP, 32'hFFFF_FFFF);
        rd(A_UNMAP, 32'd0);
        rd(A_TXD, 32'd0);

        // Overfill the TX FIFO with the sink stalled
        for (int i = 1; i <= 9; i++) wr(A_TXD, 32'(i));
        rd(A_TXS, (32'd8 << 6) | 32'h5);
        check("full_valid", {63'd0, tx_valid_o}, 64'd1);
        check("full_head",  {56'd0, tx_data_o},  64'h01);

        // Drain one byte per cycle
        tx_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("drain_data",  {56'd0, tx_data_o},  64'(i));
            check("drain_valid", {63'd0, tx_valid_o}, 64'd1);
            tick();
        end
        tx_ready_i = 1'b0;
        @(negedge clk);
        check("empty_valid", {63'd0, tx_valid_o}, 64'd0);
        check("empty_data",  {56'd0, tx_data_o},  64'd0);
        rd(A_TXS, 32'h6);
        wr(A_TXS, 32'h4);
        rd(A_TXS, 32'h2);

        // Push and pop in the same cycle keep the count
        wr(A_TXD, 32'h10);
        wr(A_TXD, 32'h11);
        tx_ready_i = 1'b1;
        wr(A_TXD, 32'h12);
        tx_ready_i = 1'b0;
        rd(A_TXS, 32'd2 << 6);
        check("pp_head", {56'd0, tx_data_o}, 64'h11);

        // Push while full is dropped even with a concurrent pop
        for (int i = 8'h13; i <= 8'h18; i++) wr(A_TXD, 32'(i));
        tx_ready_i = 1'b1;
        wr(A_TXD, 32'h99);
        tx_ready_i = 1'b0;
        rd(A_TXS, (32'd7 << 6) | 32'h4);
        check("fullpop_head", {56'd0, tx_data_o}, 64'h12);

        // Counter boundary values forced directly
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        rd(A_LO, 32'hFFFF_FFFF);
        release dut.cycle_q;
        rd(A_HI, 32'h0000_0000);
        force dut.cycle_q = 64'h0000_0007_0000_0003;
        rd(A_LO, 32'h0000_0003);
        release dut.cycle_q;
        rd(A_HI, 32'h0000_0007);

        // Reset mid-operation; the RAM write issued in the reset cycle is dropped
        wr(A_GPIO, 32'hA5);
        check("gpio_a5", {32'd0, gpio_o}, 64'hA5);
        rd(A_TXS, (32'd7 << 6) | 32'h4);
        reset        = 1'b1;
        dmem_read_i  = 1'b1;
        dmem_write_i = 1'b1;
        dmem_addr_i  = 32'h0000_0010;
        dmem_data_i  = 32'h0BAD_F00D;
        tick();
        reset        = 1'b0;
        dmem_read_i  = 1'b0;
        dmem_write_i = 1'b0;
        @(negedge clk);
        check("mid_gpio",  {32'd0, gpio_o},      64'd0);
        check("mid_valid", {63'd0, tx_valid_o},  64'd0);
        check("mid_txd",   {56'd0, tx_data_o},   64'd0);
        check("mid_dout",  {32'd0, dmem_data_o}, 64'd0);
        rd(32'h0000_0010, 32'hDEAD_BEEF);
        rd(A_TXS, 32'h2);
        rd(A_HI, 32'd0);

        repeat (2) tick();
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dmem_responder
